// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle FSM (master) and the single-bus datapath (slave).
// Datapath status flows in; enables, selects and trap flags flow out.
interface mc_ctrl_fsm_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             iord;
    logic             mem_rd;
    logic             mem_wr;
    logic             reg_we;
    logic             reg_dst;
    logic             mem_to_reg;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output ir_we, pc_we, pc_src, iord, mem_rd, mem_wr, reg_we, reg_dst,
               mem_to_reg, alu_src_b, alu_op, halted, illegal, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  ir_we, pc_we, pc_src, iord, mem_rd, mem_wr, reg_we, reg_dst,
               mem_to_reg, alu_src_b, alu_op, halted, illegal, retired
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM: memory handshake, retire counter,
// HALT/illegal-opcode traps. Outputs are Moore decode plus mem_ready/zero gating.
module mc_ctrl_fsm #(
    parameter int         CNT_W   = 16,
    parameter logic [5:0] OP_HALT = 6'h3F
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_fsm_if.master bus
);
    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI= 6'h08;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EX_R, S_EX_I, S_EX_MEM, S_EX_BEQ,
        S_MEM, S_WB_R, S_WB_I, S_WB_L, S_HALT, S_ILL
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic             w_ir_we, w_pc_we, w_iord, w_mem_rd, w_mem_wr;
    logic             w_reg_we, w_reg_dst, w_mem_to_reg, w_halted, w_illegal;
    logic [1:0]       w_pc_src, w_alu_src_b, w_alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IF;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Everything decodes to zero while reset is held, so a mid-access reset
    // drops the bus request immediately rather than at the next edge.
    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_src     = 2'd0;
        w_iord       = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_reg_we     = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_b  = 2'd0;
        w_alu_op     = 2'd0;
        w_halted     = 1'b0;
        w_illegal    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_IF: begin
                    w_mem_rd    = 1'b1;
                    w_alu_src_b = 2'd1;
                    if (bus.mem_ready) begin
                        w_ir_we = 1'b1;
                        w_pc_we = 1'b1;
                        w_next  = S_ID;
                    end
                end
                S_ID: begin
                    w_alu_src_b = 2'd3;
                    case (bus.opcode)
                        OP_R:         w_next = S_EX_R;
                        OP_LW, OP_SW: w_next = S_EX_MEM;
                        OP_BEQ:       w_next = S_EX_BEQ;
                        OP_ADDI:      w_next = S_EX_I;
                        OP_J: begin
                            w_pc_we  = 1'b1;
                            w_pc_src = 2'd2;
                            w_retire = 1'b1;
                            w_next   = S_IF;
                        end
                        default:      w_next = (bus.opcode == OP_HALT) ? S_HALT : S_ILL;
                    endcase
                end
                S_EX_R: begin
                    w_alu_op = 2'd2;
                    w_next   = S_WB_R;
                end
                S_EX_I: begin
                    w_alu_src_b = 2'd2;
                    w_next      = S_WB_I;
                end
                S_EX_MEM: begin
                    w_alu_src_b = 2'd2;
                    w_next      = S_MEM;
                end
                S_EX_BEQ: begin
                    w_alu_op = 2'd1;
                    w_pc_src = 2'd1;
                    w_pc_we  = bus.zero;
                    w_retire = 1'b1;
                    w_next   = S_IF;
                end
                S_MEM: begin
                    w_iord = 1'b1;
                    // Only lw/sw reach here; anything but lw is treated as a store.
                    if (bus.opcode == OP_LW) begin
                        w_mem_rd = 1'b1;
                        if (bus.mem_ready) w_next = S_WB_L;
                    end else begin
                        w_mem_wr = 1'b1;
                        if (bus.mem_ready) begin
                            w_retire = 1'b1;
                            w_next   = S_IF;
                        end
                    end
                end
                S_WB_R: begin
                    w_reg_we  = 1'b1;
                    w_reg_dst = 1'b1;
                    w_retire  = 1'b1;
                    w_next    = S_IF;
                end
                S_WB_I: begin
                    w_reg_we = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_IF;
                end
                S_WB_L: begin
                    w_reg_we     = 1'b1;
                    w_mem_to_reg = 1'b1;
                    w_retire     = 1'b1;
                    w_next       = S_IF;
                end
                S_HALT:  w_halted  = 1'b1;
                S_ILL:   w_illegal = 1'b1;
                default: w_next    = S_IF;
            endcase
        end
    end

    assign bus.ir_we      = w_ir_we;
    assign bus.pc_we      = w_pc_we;
    assign bus.pc_src     = w_pc_src;
    assign bus.iord       = w_iord;
    assign bus.mem_rd     = w_mem_rd;
    assign bus.mem_wr     = w_mem_wr;
    assign bus.reg_we     = w_reg_we;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.halted     = w_halted;
    assign bus.illegal    = w_illegal;
    assign bus.retired    = r_retired;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: each cycle's expected outputs are queued as
// the inputs are driven, then popped and checked mid-cycle.
module tb_mc_ctrl_fsm;
    localparam int CW = 4;

    typedef struct packed {
        logic          ir_we;
        logic          pc_we;
        logic [1:0]    pc_src;
        logic          iord;
        logic          mem_rd;
        logic          mem_wr;
        logic          reg_we;
        logic          reg_dst;
        logic          mem_to_reg;
        logic [1:0]    alu_src_b;
        logic [1:0]    alu_op;
        logic          halted;
        logic          illegal;
        logic [CW-1:0] retired;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    int            n_chk = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_ret = '0;
    exp_t          sb[$];

    mc_ctrl_fsm_if #(.CNT_W(CW)) bus ();

    mc_ctrl_fsm #(.CNT_W(CW), .OP_HALT(6'h3F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Expected output patterns, one per FSM state as listed in the control table.
    function automatic exp_t f_zero();
        return '0;
    endfunction
    function automatic exp_t f_if(input logic rdy);
        exp_t e = '0;
        e.mem_rd = 1'b1; e.alu_src_b = 2'd1; e.ir_we = rdy; e.pc_we = rdy;
        return e;
    endfunction
    function automatic exp_t f_id(input logic jmp);
        exp_t e = '0;
        e.alu_src_b = 2'd3;
        if (jmp) begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
        return e;
    endfunction
    function automatic exp_t f_ex(input logic [1:0] srcb, input logic [1:0] op);
        exp_t e = '0;
        e.alu_src_b = srcb; e.alu_op = op;
        return e;
    endfunction
    function automatic exp_t f_beq(input logic z);
        exp_t e = '0;
        e.alu_op = 2'd1; e.pc_src = 2'd1; e.pc_we = z;
        return e;
    endfunction
    function automatic exp_t f_mem(input logic lw);
        exp_t e = '0;
        e.iord = 1'b1; e.mem_rd = lw; e.mem_wr = ~lw;
        return e;
    endfunction
    function automatic exp_t f_wb(input logic dst, input logic m2r);
        exp_t e = '0;
        e.reg_we = 1'b1; e.reg_dst = dst; e.mem_to_reg = m2r;
        return e;
    endfunction
    function automatic exp_t f_trap(input logic h);
        exp_t e = '0;
        e.halted = h; e.illegal = ~h;
        return e;
    endfunction

    task automatic check(input string tag);
        exp_t e, got;
        e   = sb.pop_front();
        got = {bus.ir_we, bus.pc_we, bus.pc_src, bus.iord, bus.mem_rd, bus.mem_wr,
               bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.alu_src_b, bus.alu_op,
               bus.halted, bus.illegal, bus.retired};
        n_chk++;
        assert (got === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, e);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic z,
                        input logic rdy, input exp_t e);
        @(negedge clk);
        bus.opcode = op; bus.zero = z; bus.mem_ready = rdy;
        e.retired = exp_ret;
        sb.push_back(e);
        #1 check(tag);
    endtask

    task automatic release_rst();
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        sb.push_back(f_if(1'b0));
        check("release_fetch");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_ret = '0;
        #1;
        sb.push_back(f_zero());
        check("reset_idle");
        release_rst();
    endtask

    task automatic do_r();
        step("r_if",  6'h00, 1'b0, 1'b1, f_if(1'b1));
        step("r_id",  6'h00, 1'b0, 1'b1, f_id(1'b0));
        step("r_ex",  6'h00, 1'b0, 1'b1, f_ex(2'd0, 2'd2));
        step("r_wb",  6'h00, 1'b0, 1'b1, f_wb(1'b1, 1'b0));
        exp_ret++;
    endtask

    task automatic do_addi();
        step("i_if",  6'h08, 1'b0, 1'b1, f_if(1'b1));
        step("i_id",  6'h08, 1'b0, 1'b0, f_id(1'b0));
        step("i_ex",  6'h08, 1'b1, 1'b1, f_ex(2'd2, 2'd0));
        step("i_wb",  6'h08, 1'b0, 1'b1, f_wb(1'b0, 1'b0));
        exp_ret++;
    endtask

    task automatic do_beq(input logic z);
        step("beq_if", 6'h04, 1'b0, 1'b1, f_if(1'b1));
        step("beq_id", 6'h04, 1'b0, 1'b1, f_id(1'b0));
        step("beq_ex", 6'h04, z,    1'b1, f_beq(z));
        exp_ret++;
    endtask

    task automatic do_j();
        step("j_if", 6'h02, 1'b0, 1'b1, f_if(1'b1));
        step("j_id", 6'h02, 1'b0, 1'b1, f_id(1'b1));
        exp_ret++;
    endtask

    task automatic do_sw();
        step("sw_if",  6'h2B, 1'b0, 1'b1, f_if(1'b1));
        step("sw_id",  6'h2B, 1'b0, 1'b1, f_id(1'b0));
        step("sw_ex",  6'h2B, 1'b0, 1'b1, f_ex(2'd2, 2'd0));
        step("sw_mem", 6'h2B, 1'b0, 1'b1, f_mem(1'b0));
        exp_ret++;
    endtask

    initial begin
        bus.opcode = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        #2;
        sb.push_back(f_zero());
        check("por_idle");
        release_rst();

        // Three back-to-back R-type instructions, zero-wait memory.
        for (int k = 0; k < 3; k++) do_r();

        // lw: two fetch wait states, three data wait states (10 cycles total).
        for (int k = 0; k < 2; k++) step("lw_if_wait", 6'h23, 1'b0, 1'b0, f_if(1'b0));
        step("lw_if",  6'h23, 1'b0, 1'b1, f_if(1'b1));
        step("lw_id",  6'h23, 1'b0, 1'b1, f_id(1'b0));
        step("lw_ex",  6'h23, 1'b0, 1'b1, f_ex(2'd2, 2'd0));
        for (int k = 0; k < 3; k++) step("lw_mem_wait", 6'h23, 1'b0, 1'b0, f_mem(1'b1));
        step("lw_mem", 6'h23, 1'b0, 1'b1, f_mem(1'b1));
        step("lw_wb",  6'h23, 1'b0, 1'b1, f_wb(1'b0, 1'b1));
        exp_ret++;

        do_beq(1'b1);
        do_beq(1'b0);
        do_j();
        do_sw();
        do_addi();
        step("post_addi_fetch", 6'h00, 1'b0, 1'b0, f_if(1'b0));

        // Asynchronous reset landing mid data access.
        step("ar_if",  6'h23, 1'b0, 1'b1, f_if(1'b1));
        step("ar_id",  6'h23, 1'b0, 1'b1, f_id(1'b0));
        step("ar_ex",  6'h23, 1'b0, 1'b1, f_ex(2'd2, 2'd0));
        step("ar_mem", 6'h23, 1'b0, 1'b0, f_mem(1'b1));
        #2 rst_n = 1'b0;
        exp_ret = '0;
        #1;
        sb.push_back(f_zero());
        check("async_reset_mid_mem");
        release_rst();

        // Counter wrap: 17 jumps walk past 2^CW-1 back through zero.
        for (int k = 0; k < 17; k++) do_j();
        step("wrap_fetch", 6'h00, 1'b0, 1'b0, f_if(1'b0));

        // HALT trap: sticky, no fetch, retire count frozen.
        step("halt_if", 6'h3F, 1'b0, 1'b1, f_if(1'b1));
        step("halt_id", 6'h3F, 1'b0, 1'b1, f_id(1'b0));
        for (int k = 0; k < 20; k++) step("halt_hold", 6'h00, 1'b1, 1'b1, f_trap(1'b1));
        do_reset();

        // Illegal opcode trap.
        step("ill_if", 6'h11, 1'b0, 1'b1, f_if(1'b1));
        step("ill_id", 6'h11, 1'b0, 1'b1, f_id(1'b0));
        for (int k = 0; k < 20; k++) step("ill_hold", 6'h00, 1'b0, 1'b1, f_trap(1'b0));
        do_reset();
        do_r();
        step("final_fetch", 6'h00, 1'b0, 1'b0, f_if(1'b0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
